// File: rtl/rv_core_pkg.sv
// Shared encodings, ALU op enum and decoded-control bundle
// for the three-stage RV32I-subset core.
package rv_core_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_PASS
    } alu_op_e;

    typedef struct packed {
        logic    reg_wen;
        logic    use_imm;
        logic    is_branch;
        logic    is_halt;
        alu_op_e alu_op;
    } ctrl_t;

    // Unrecognised encodings fall through as a NOP.
    function automatic ctrl_t decode(input logic [31:0] ins);
        ctrl_t c;
        c.reg_wen   = 1'b0;
        c.use_imm   = 1'b0;
        c.is_branch = 1'b0;
        c.is_halt   = 1'b0;
        c.alu_op    = ALU_PASS;
        case (ins[6:0])
            OP_R: begin
                if (ins[31:25] == F7_SUB && ins[14:12] == F3_ADD) begin
                    c.reg_wen = 1'b1;
                    c.alu_op  = ALU_SUB;
                end else if (ins[31:25] == F7_BASE) begin
                    case (ins[14:12])
                        F3_ADD: begin c.reg_wen = 1'b1; c.alu_op = ALU_ADD; end
                        F3_AND: begin c.reg_wen = 1'b1; c.alu_op = ALU_AND; end
                        F3_OR:  begin c.reg_wen = 1'b1; c.alu_op = ALU_OR;  end
                        F3_XOR: begin c.reg_wen = 1'b1; c.alu_op = ALU_XOR; end
                        default: ;
                    endcase
                end
            end
            OP_I: begin
                if (ins[14:12] == F3_ADD) begin
                    c.reg_wen = 1'b1;
                    c.use_imm = 1'b1;
                    c.alu_op  = ALU_ADD;
                end
            end
            OP_B: begin
                if (ins[14:12] == F3_BEQ)
                    c.is_branch = 1'b1;
            end
            OP_SYS: c.is_halt = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rv_regfile.sv
// Register file: two async read ports, one sync write port,
// x0 and out-of-range indices read as zero and ignore writes.
module rv_regfile
    import rv_core_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [4:0]            waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [4:0]            raddr_a,
    input  logic [4:0]            raddr_b,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic [DATA_WIDTH-1:0] rdata_b
);

    localparam int AW = $clog2(NUM_REGS);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  wr_ok;

    assign wr_ok = we && (waddr != 5'd0) && (32'(waddr) < NUM_REGS);

    always_comb begin
        regs_d = regs_q;
        if (wr_ok)
            regs_d[waddr[AW-1:0]] = wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (raddr_a != 5'd0 && 32'(raddr_a) < NUM_REGS)
            rdata_a = regs_q[raddr_a[AW-1:0]];
        if (raddr_b != 5'd0 && 32'(raddr_b) < NUM_REGS)
            rdata_b = regs_q[raddr_b[AW-1:0]];
    end

endmodule

// File: rtl/pipelined_rv_core.sv
// Three-stage IF/EX/WB core with byte loader, WB->EX forwarding,
// taken-branch flush and halt.
module pipelined_rv_core
    import rv_core_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 32,
    parameter int PM_DEPTH   = 32,
    parameter int PCW        = $clog2(PM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  load_en,
    input  logic [PCW+1:0]        load_addr,
    input  logic [7:0]            load_data,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_valid,
    output logic [4:0]            wb_reg,
    output logic [PCW-1:0]        pc,
    output logic                  halted
);

    logic [31:0] pm_q [PM_DEPTH];

    logic [PCW-1:0]        pc_q, pc_d;
    logic [31:0]           ifid_q, ifid_d;
    logic [PCW-1:0]        ifid_pc_q, ifid_pc_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  result_valid_q, result_valid_d;
    logic [4:0]            wb_reg_q, wb_reg_d;
    logic                  halted_q, halted_d;

    ctrl_t                 ctrl;
    logic [4:0]            rs1, rs2, rd;
    logic [DATA_WIDTH-1:0] rf_a, rf_b;
    logic [DATA_WIDTH-1:0] opa, opb, alu_b, alu_y, imm;
    logic [12:0]           bimm;
    logic [PCW-1:0]        br_tgt;
    logic                  fwd_a, fwd_b, taken, wen_ex;

    // Program memory is only written in load mode and never reset.
    always_ff @(posedge clk) begin
        if (load_en && !run)
            pm_q[load_addr[PCW+1:2]][{load_addr[1:0], 3'b000} +: 8] <= load_data;
    end

    assign ctrl = decode(ifid_q);
    assign rs1  = ifid_q[19:15];
    assign rs2  = ifid_q[24:20];
    assign rd   = ifid_q[11:7];
    assign imm  = DATA_WIDTH'($signed(ifid_q[31:20]));
    assign bimm = {ifid_q[31], ifid_q[7], ifid_q[30:25], ifid_q[11:8], 1'b0};

    assign br_tgt = ifid_pc_q + PCW'($signed(bimm) >>> 2);

    rv_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (result_valid_q),
        .waddr   (wb_reg_q),
        .wdata   (result_q),
        .raddr_a (rs1),
        .raddr_b (rs2),
        .rdata_a (rf_a),
        .rdata_b (rf_b)
    );

    assign fwd_a = result_valid_q && (wb_reg_q == rs1) && (rs1 != 5'd0);
    assign fwd_b = result_valid_q && (wb_reg_q == rs2) && (rs2 != 5'd0);
    assign opa   = fwd_a ? result_q : rf_a;
    assign opb   = fwd_b ? result_q : rf_b;
    assign alu_b = ctrl.use_imm ? imm : opb;

    always_comb begin
        alu_y = alu_b;
        case (ctrl.alu_op)
            ALU_ADD:  alu_y = opa + alu_b;
            ALU_SUB:  alu_y = opa - alu_b;
            ALU_AND:  alu_y = opa & alu_b;
            ALU_OR:   alu_y = opa | alu_b;
            ALU_XOR:  alu_y = opa ^ alu_b;
            default:  alu_y = alu_b;
        endcase
    end

    assign taken  = ctrl.is_branch && (opa == opb);
    assign wen_ex = ctrl.reg_wen && (rd != 5'd0) && (32'(rd) < NUM_REGS);

    always_comb begin
        pc_d           = pc_q + PCW'(1);
        ifid_d         = pm_q[pc_q];
        ifid_pc_d      = pc_q;
        halted_d       = halted_q;
        result_d       = alu_y;
        result_valid_d = wen_ex;
        wb_reg_d       = wen_ex ? rd : 5'd0;
        if (halted_q || ctrl.is_halt) begin
            halted_d = 1'b1;
            pc_d     = pc_q;
            ifid_d   = NOP_INSTR;
        end else if (taken) begin
            pc_d   = br_tgt;
            ifid_d = NOP_INSTR;
        end
        // Load/idle mode keeps the pipeline empty and parked at word 0.
        if (!run) begin
            pc_d           = '0;
            ifid_d         = NOP_INSTR;
            ifid_pc_d      = '0;
            halted_d       = 1'b0;
            result_d       = '0;
            result_valid_d = 1'b0;
            wb_reg_d       = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q           <= '0;
            ifid_q         <= NOP_INSTR;
            ifid_pc_q      <= '0;
            halted_q       <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            wb_reg_q       <= 5'd0;
        end else begin
            pc_q           <= pc_d;
            ifid_q         <= ifid_d;
            ifid_pc_q      <= ifid_pc_d;
            halted_q       <= halted_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            wb_reg_q       <= wb_reg_d;
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign wb_reg       = wb_reg_q;
    assign pc           = pc_q;
    assign halted       = halted_q;

endmodule

// File: doc/pipelined_rv_core.md
# pipelined_rv_core

Parametrised three-stage (IF, EX, WB) RV32I-subset core with on-chip program memory, byte-serial program loader, register forwarding, taken-branch flush and halt. It succeeds the fixed 8-bit core: data width, register count and program depth are parameters. It adds BEQ, an explicit run/halt control and a result-valid strobe. It sits at the top of the tile design, loaded over a byte interface and observed through its writeback port.

## Interface
- DATA_WIDTH, 8: datapath and register width; legal 8..32.
- NUM_REGS, 32: architectural registers; 16 or 32.
- PM_DEPTH, 32: program memory depth in 32-bit words; power of two.
- PCW, $clog2(PM_DEPTH): PC width (derived, word index).
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  1 = execute; 0 = idle/load mode.
- load_en  in  1  program byte write strobe; honoured only when run=0.
- load_addr  in  PCW+2  byte address; word = load_addr[PCW+1:2], byte lane = load_addr[1:0], little-endian.
- load_data  in  8  program byte.
- result  out  DATA_WIDTH  EX/WB result register.
- result_valid  out  1  register write in WB this cycle (rd≠x0).
- wb_reg  out  5  destination of the current WB.
- pc  out  PCW  current fetch address.
- halted  out  1  halt instruction retired from EX.

## Operation
- Supported: ADD/SUB/AND/OR/XOR (opcode 0110011; funct3 000/000/111/110/100; SUB funct7 0100000), ADDI (0010011, funct3 000), BEQ (1100011, funct3 000), HALT (1110011). Any other encoding is a NOP: no write, no branch.
- Immediates sign-extended from 12 bits, then truncated to DATA_WIDTH. All arithmetic is modulo 2^DATA_WIDTH. BEQ compares the full DATA_WIDTH.
- BEQ target = branch PC + (B-imm >>> 2), modulo PM_DEPTH. PC increments modulo PM_DEPTH (wraps to 0).
- x0 reads 0; writes to x0 discarded. rs/rd ≥ NUM_REGS: read 0, write discarded.
- Forwarding: when the EX source register equals wb_reg, WB is writing and the register is ≠ x0, the operand is taken from result. The forward is applied per operand, so both operands may forward together.
- Taken BEQ in EX: PC ← target and IF/ID ← NOP (0x00000013).
- HALT in EX: halted ← 1, PC frozen, IF/ID ← NOP. The instruction already in WB completes. halted stays set until rst or run=0.
- run=0: PC, pipeline registers and halted are cleared every cycle; register file retained. Loads write PM at the edge.
- load_en with run=1 is ignored. Program memory is never cleared by reset.

## Timing
- Reset values: pc=0, halted=0, result=0, result_valid=0, wb_reg=0, IF/ID=NOP, EX/WB invalid, all registers 0.
- PM read is combinational at pc; IF/ID is captured at the edge.
- The instruction at pc in cycle t executes in t+1. It appears on result/result_valid in t+2, and its register write commits at the end of t+2.
- Throughput is 1 instruction/cycle. A taken branch costs 1 bubble; no stalls exist.
- First fetch is from word 0 in the first cycle with run=1 after run=0 or rst.
- rst mid-execution: all state except PM clears at that edge, including the register file.
- run falling mid-execution: in-flight instructions are discarded; no WB occurs on the following cycle.

## Structure
- Package rv_core_pkg: opcode and funct constants, the alu_op enum (ADD, SUB, AND, OR, XOR, PASS), NOP_INSTR, and a decoded-control struct (reg_wen, use_imm, is_branch, is_halt, alu_op).
- Sub-module rv_regfile: NUM_REGS×DATA_WIDTH, 2 asynchronous read ports, 1 synchronous write port, synchronous clear on rst.
- Core holds PM, loader, PC, IF/ID, decode, ALU, forwarding, EX/WB.

## Test plan
- Load ADDI x1,x0,5; ADDI x2,x0,7; ADD x3,x1,x2; HALT, then run → result 5,7,12 on consecutive valid cycles, wb_reg 1,2,3; halted=1 one cycle after x3's EX stage.
- DATA_WIDTH=8: ADDI x1,x0,-1; ADDI x1,x1,2 → x1=0x01 (wrap); DATA_WIDTH=16 → 0x0001, with intermediate 0xFFFF.
- Back-to-back dependency ADDI x1,x0,3; ADD x2,x1,x1 → x2=6 via forwarding, no stall.
- BEQ x0,x0,+8 at word 2 → word 3 never writes; word 4 executes; exactly one bubble (result_valid low one cycle).
- Write x0 (ADDI x0,x0,9) then ADD x1,x0,x0 → result_valid low for the first, x1=0.
- Assert rst mid-run, then run=1 → registers read 0; program still executes from word 0 with memory intact. Loader writes during run=1 → memory unchanged.
